// File: rtl/uart_tx_fifo_launcher.sv
// uart_tx_fifo_launcher
//   Byte FIFO feeding the UART Tx control unit. Bytes pushed from the APB side
//   are queued. One byte is popped per frame and held on tx_data. A one-cycle
//   data_valid pulse starts the frame. The launcher then waits for tx_busy to
//   drop before it launches the next byte.
//
//   Optional build macro: UART_TX_PARITY_GEN_EN
//     defined   -> parity_bit = ^byte ^ parity_type, captured at pop time
//     undefined -> parity_bit tied low, no parity logic
//
// Ports
//   UCLK, reset        clock, async active-low reset
//   wr_en, wr_data     push request / byte
//   ovf_clr            clears sticky overflow (a same-cycle drop wins)
//   parity_type        0 even, 1 odd
//   tx_busy            busy from the Tx control unit
//   data_valid         registered 1-cycle launch pulse
//   tx_data            byte held for the whole frame
//   parity_bit         parity of tx_data
//   full/empty/count   registered occupancy flags and count
//   overflow           sticky dropped-write flag
module uart_tx_fifo_launcher #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     UCLK,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     ovf_clr,
  input  logic                     parity_type,
  input  logic                     tx_busy,
  output logic                     data_valid,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     parity_bit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [1:0]            state;
  logic                  pop, push, drop;
  logic [AW:0]           count_nxt;
  logic [DATA_WIDTH-1:0] head;

  assign head = mem[rd_ptr];

  // Pop only from IDLE with the control unit free. A pop frees a slot, so a
  // push on a full FIFO in the same cycle is still accepted.
  assign pop  = (state == IDLE) && !empty && !tx_busy;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && !push;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge UCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are power-of-two wide, so they wrap DEPTH-1 -> 0 by themselves.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Launch FSM. The first WAIT cycle always sees busy high because the
  // control unit raises busy one cycle after the pulse.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      data_valid <= 1'b0;
      tx_data    <= '0;
    end else begin
      data_valid <= pop;
      if (pop) tx_data <= head;
      case (state)
        IDLE:    if (pop) state <= LAUNCH;
        LAUNCH:  state <= WAIT;
        WAIT:    if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_PARITY_GEN_EN
  // parity_type is sampled together with the byte, so it cannot change mid-frame.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= (^head) ^ parity_type;
  end
`else
  logic unused_parity_type;
  assign unused_parity_type = parity_type;
  assign parity_bit         = 1'b0;
`endif

endmodule
